// File: rtl/axi4_frame_reader_pkg.sv
// Shared types and constants for the AXI4 frame reader.
// FSM encodings, fixed AR attributes and burst geometry.
package axi4_frame_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ADDR  = 2'd2,
        DATA  = 2'd3
    } state_t;

    localparam logic [2:0] AXI_ARSIZE  = 3'b011;
    localparam logic [1:0] AXI_ARBURST = 2'b01;
    localparam logic [3:0] AXI_ARCACHE = 4'b0011;
    localparam logic [2:0] AXI_ARPROT  = 3'b000;
    localparam logic [1:0] RRESP_OKAY  = 2'b00;

    localparam int BURST_BYTES = 128;

endpackage

// File: rtl/axi_rd_beat_checker.sv
// Counts accepted read beats and flags protocol/response errors.
// burst_end fires on RLAST or on the final expected beat, whichever first.
module axi_rd_beat_checker
    import axi4_frame_reader_pkg::*;
#(
    parameter int BURST_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       beat,
    input  logic       rlast,
    input  logic [1:0] rresp,
    output logic       burst_end,
    output logic       beat_err
);

    logic [7:0] beat_cnt;
    logic       final_beat;

    assign final_beat = (beat_cnt == 8'(BURST_LEN - 1));
    assign burst_end  = beat && (rlast || final_beat);

    // Early RLAST and missing RLAST both show up as rlast != final_beat.
    assign beat_err = beat &&
        ((rresp != RRESP_OKAY) || (rlast != final_beat));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (clr) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/axi4_frame_reader.sv
// Reads one frame from DDR as 128-byte AXI4 INCR bursts, one in flight,
// throttled by downstream FIFO fullness.
module axi4_frame_reader
    import axi4_frame_reader_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int BURST_LEN      = 16,
    parameter int FRAME_BYTES    = 614400
) (
    input  logic                      clk_100Mhz,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic                      RLAST,
    input  logic [1:0]                RRESP,
    output logic [AXI_DATA_WIDTH-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_prog_full,
    output logic                      frame_busy,
    output logic                      frame_done,
    output logic                      o_rd_err,
    output logic [1:0]                state,
    output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
);

    localparam logic [AXI_ADDR_WIDTH-1:0] STEP =
        AXI_ADDR_WIDTH'(BURST_BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] FRAME_END =
        AXI_ADDR_WIDTH'(FRAME_BYTES);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~AXI_ADDR_WIDTH'(BURST_BYTES - 1);

    state_t                    st;
    state_t                    st_nxt;
    logic [AXI_ADDR_WIDTH-1:0] base_q;
    logic                      start_ok;
    logic                      rd_beat;
    logic                      ar_hs;
    logic                      burst_end;
    logic                      beat_err;
    logic                      last_burst;

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = AXI_ARSIZE;
    assign ARBURST = AXI_ARBURST;
    assign ARCACHE = AXI_ARCACHE;
    assign ARPROT  = AXI_ARPROT;

    assign ARVALID    = (st == ADDR);
    assign RREADY     = (st == DATA);
    assign frame_busy = (st != IDLE);
    assign state      = st;
    assign ARADDR     = base_q + ADDR_OFFSET;

    assign start_ok   = (st == IDLE) && frame_start;
    assign rd_beat    = RVALID && RREADY;
    assign ar_hs      = ARVALID && ARREADY;
    assign last_burst = (ADDR_OFFSET + STEP) == FRAME_END;

    axi_rd_beat_checker #(
        .BURST_LEN (BURST_LEN)
    ) u_chk (
        .clk       (clk_100Mhz),
        .rst       (rst),
        .clr       (ar_hs),
        .beat      (rd_beat),
        .rlast     (RLAST),
        .rresp     (RRESP),
        .burst_end (burst_end),
        .beat_err  (beat_err)
    );

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            IDLE:  if (frame_start) st_nxt = CHECK;
            CHECK: if (!i_prog_full) st_nxt = ADDR;
            ADDR:  if (ARREADY) st_nxt = DATA;
            DATA:  if (burst_end) st_nxt = last_burst ? IDLE : CHECK;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            ADDR_OFFSET <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            frame_done  <= 1'b0;
            o_rd_err    <= 1'b0;
        end else begin
            o_valid    <= rd_beat;
            frame_done <= burst_end && last_burst;
            if (rd_beat) begin
                o_data <= RDATA;
            end
            if (start_ok) begin
                base_q      <= FRAME_BASE_ADDR & ALIGN_MASK;
                ADDR_OFFSET <= '0;
                o_rd_err    <= 1'b0;
            end else begin
                if (beat_err) begin
                    o_rd_err <= 1'b1;
                end
                if (burst_end && !last_burst) begin
                    ADDR_OFFSET <= ADDR_OFFSET + STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Directed bench for axi4_frame_reader with a 512-byte frame.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi4_frame_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [31:0] base;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic [63:0] RDATA;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic [63:0] o_data;
    logic        o_valid;
    logic        prog_full;
    logic        frame_busy;
    logic        frame_done;
    logic        o_rd_err;
    logic [1:0]  state;
    logic [31:0] ADDR_OFFSET;

    int total = 0;
    int bad   = 0;
    int words = 0;
    int dones = 0;
    int w0;
    int d0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_valid) words++;
        if (frame_done) dones++;
    end

    axi4_frame_reader #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (64),
        .BURST_LEN      (16),
        .FRAME_BYTES    (512)
    ) dut (
        .clk_100Mhz      (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .FRAME_BASE_ADDR (base),
        .ARADDR          (ARADDR),
        .ARVALID         (ARVALID),
        .ARREADY         (ARREADY),
        .ARLEN           (ARLEN),
        .ARSIZE          (ARSIZE),
        .ARBURST         (ARBURST),
        .ARCACHE         (ARCACHE),
        .ARPROT          (ARPROT),
        .RDATA           (RDATA),
        .RVALID          (RVALID),
        .RREADY          (RREADY),
        .RLAST           (RLAST),
        .RRESP           (RRESP),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .i_prog_full     (prog_full),
        .frame_busy      (frame_busy),
        .frame_done      (frame_done),
        .o_rd_err        (o_rd_err),
        .state           (state),
        .ADDR_OFFSET     (ADDR_OFFSET)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a);
        base = a;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Wait for AR, check it, accept after arw cycles, then drive nb beats.
    task automatic burst(input logic [31:0] a, input int arw,
                         input int bad_b, input int last_b, input int nb);
        int n = 0;
        while (!ARVALID && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("arvalid_up", 64'(ARVALID), 64'd1);
        chk("araddr", 64'(ARADDR), 64'(a));
        for (int i = 0; i < arw; i++) begin
            @(negedge clk);
            chk("ar_hold_valid", 64'(ARVALID), 64'd1);
            chk("ar_hold_addr", 64'(ARADDR), 64'(a));
        end
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        chk("ar_drop", 64'(ARVALID), 64'd0);
        chk("rready", 64'(RREADY), 64'd1);
        for (int b = 1; b <= nb; b++) begin
            RVALID = 1'b1;
            RDATA  = {a, 32'(b)};
            RRESP  = (b == bad_b) ? 2'b10 : 2'b00;
            RLAST  = (b == last_b);
            @(negedge clk);
            chk("o_valid", 64'(o_valid), 64'd1);
            chk("o_data", o_data, {a, 32'(b)});
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RRESP  = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        base = '0;
        ARREADY = 1'b0;
        RDATA = '0;
        RVALID = 1'b0;
        RLAST = 1'b0;
        RRESP = 2'b00;
        prog_full = 1'b0;
        repeat (3) @(negedge clk);

        // reset values and constant AR attributes
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_rready", 64'(RREADY), 64'd0);
        chk("rst_ovalid", 64'(o_valid), 64'd0);
        chk("rst_busy", 64'(frame_busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(o_rd_err), 64'd0);
        chk("rst_off", 64'(ADDR_OFFSET), 64'd0);
        chk("rst_araddr", 64'(ARADDR), 64'd0);
        chk("rst_odata", o_data, 64'd0);
        chk("arlen", 64'(ARLEN), 64'd15);
        chk("arsize", 64'(ARSIZE), 64'd3);
        chk("arburst", 64'(ARBURST), 64'd1);
        chk("arcache", 64'(ARCACHE), 64'd3);
        chk("arprot", 64'(ARPROT), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rready", 64'(RREADY), 64'd0);

        // frame 1: four clean bursts
        w0 = words;
        d0 = dones;
        start(32'h1000_0000);
        chk("f1_busy", 64'(frame_busy), 64'd1);
        chk("f1_check", 64'(state), 64'd1);
        burst(32'h1000_0000, 2, 0, 16, 16);
        chk("f1_off1", 64'(ADDR_OFFSET), 64'h80);
        burst(32'h1000_0080, 2, 0, 16, 16);
        burst(32'h1000_0100, 2, 0, 16, 16);
        burst(32'h1000_0180, 2, 0, 16, 16);
        chk("f1_done_now", 64'(frame_done), 64'd1);
        chk("f1_idle", 64'(state), 64'd0);
        repeat (3) @(negedge clk);
        chk("f1_words", 64'(words - w0), 64'd64);
        chk("f1_dones", 64'(dones - d0), 64'd1);
        chk("f1_busy_end", 64'(frame_busy), 64'd0);
        chk("f1_err", 64'(o_rd_err), 64'd0);

        // frame 2: bad RRESP on beat 5, FIFO stall after first burst
        w0 = words;
        d0 = dones;
        start(32'h1000_0000);
        burst(32'h1000_0000, 2, 5, 16, 16);
        chk("f2_err", 64'(o_rd_err), 64'd1);
        prog_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("pf_state", 64'(state), 64'd1);
            chk("pf_arvalid", 64'(ARVALID), 64'd0);
        end
        prog_full = 1'b0;
        @(negedge clk);
        chk("pf_release_ar", 64'(ARVALID), 64'd1);
        burst(32'h1000_0080, 0, 0, 16, 16);
        burst(32'h1000_0100, 1, 0, 16, 16);
        burst(32'h1000_0180, 1, 0, 16, 16);
        chk("f2_err_at_done", 64'(o_rd_err), 64'd1);
        repeat (3) @(negedge clk);
        chk("f2_words", 64'(words - w0), 64'd64);
        chk("f2_dones", 64'(dones - d0), 64'd1);

        // frame 3: unaligned base, early RLAST, ignored restart, reset
        start(32'h1000_0047);
        chk("f3_err_clr", 64'(o_rd_err), 64'd0);
        burst(32'h1000_0000, 1, 0, 12, 12);
        chk("early_err", 64'(o_rd_err), 64'd1);
        chk("early_state", 64'(state), 64'd1);
        chk("early_off", 64'(ADDR_OFFSET), 64'h80);
        base = 32'h2000_0000;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("restart_err", 64'(o_rd_err), 64'd1);
        burst(32'h1000_0080, 1, 0, 16, 4);
        chk("pre_rst_state", 64'(state), 64'd3);
        rst = 1'b1;
        #1;
        chk("mid_state", 64'(state), 64'd0);
        chk("mid_arvalid", 64'(ARVALID), 64'd0);
        chk("mid_rready", 64'(RREADY), 64'd0);
        chk("mid_ovalid", 64'(o_valid), 64'd0);
        chk("mid_busy", 64'(frame_busy), 64'd0);
        chk("mid_done", 64'(frame_done), 64'd0);
        chk("mid_err", 64'(o_rd_err), 64'd0);
        chk("mid_off", 64'(ADDR_OFFSET), 64'd0);
        chk("mid_araddr", 64'(ARADDR), 64'd0);
        chk("mid_odata", o_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // frame 4: RLAST never arrives, burst still ends at beat 16
        start(32'h3000_0000);
        burst(32'h3000_0000, 0, 0, 99, 16);
        chk("norlast_err", 64'(o_rd_err), 64'd1);
        chk("norlast_state", 64'(state), 64'd1);
        chk("norlast_off", 64'(ADDR_OFFSET), 64'h80);
        chk("norlast_rready", 64'(RREADY), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_frame_reader.md
AXI4_FRAME_READER -- requirements
Module: axi4_frame_reader

Interface
REQ-001 SHALL have parameters, one per line:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 64, AXI data width.
- BURST_LEN, 16, beats per burst.
- FRAME_BYTES, 614400, bytes per frame (640x480x2); multiple of 128.
REQ-002 SHALL have ports, one per line:
- clk_100Mhz  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; starts a frame read.
- FRAME_BASE_ADDR  in  32  frame base in DDR.
- ARADDR  out  32  read burst address.
- ARVALID  out  1  address valid.
- ARREADY  in  1  address accepted.
- ARLEN  out  8  constant BURST_LEN-1.
- ARSIZE  out  3  constant 3'b011 (8 bytes).
- ARBURST  out  2  constant 2'b01 (INCR).
- ARCACHE  out  4  constant 4'b0011.
- ARPROT  out  3  constant 3'b000.
- RDATA  in  64  read data.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data accepted.
- RLAST  in  1  last beat.
- RRESP  in  2  read response.
- o_data  out  64  pixel word to downstream display FIFO.
- o_valid  out  1  o_data qualifier.
- i_prog_full  in  1  downstream FIFO has fewer than BURST_LEN free words.
- frame_busy  out  1  frame read in progress.
- frame_done  out  1  one-cycle pulse after the last burst completes.
- o_rd_err  out  1  sticky error flag.
- state  out  2  FSM state, for debug.
- ADDR_OFFSET  out  32  byte offset of the current burst.

Function
REQ-003 FSM states SHALL be IDLE=0, CHECK=1, ADDR=2, DATA=3.
REQ-004 IDLE: on frame_start SHALL latch FRAME_BASE_ADDR with bits[6:0] forced to 0, clear ADDR_OFFSET, set frame_busy, and go to CHECK.
REQ-005 CHECK: SHALL go to ADDR in the first cycle i_prog_full=0; otherwise it SHALL hold.
REQ-006 ADDR: ARVALID=1 and ARADDR=base+ADDR_OFFSET SHALL be held stable until ARVALID&&ARREADY; that cycle SHALL go to DATA and clear the beat counter.
REQ-007 DATA: RREADY SHALL be 1; each RVALID&&RREADY SHALL increment the beat counter.
REQ-008 On any RVALID&&RREADY, o_data SHALL equal RDATA and o_valid=1 in the next cycle (1-cycle latency); otherwise o_valid=0.
REQ-009 On the RLAST beat: if ADDR_OFFSET+128 equals FRAME_BYTES, the block SHALL return to IDLE, clear frame_busy, and pulse frame_done; otherwise it SHALL add 128 to ADDR_OFFSET and go to CHECK.
REQ-010 In IDLE, RREADY SHALL be 0. ARVALID SHALL be 1 only in ADDR. At most one burst SHALL be outstanding.
REQ-011 frame_start while frame_busy=1 SHALL be ignored.
REQ-012 RRESP!=2'b00 on any beat SHALL set o_rd_err; the data SHALL still be forwarded.
REQ-013 RLAST on a beat other than beat BURST_LEN SHALL set o_rd_err.
REQ-014 RLAST missing on beat BURST_LEN SHALL set o_rd_err, and the burst SHALL end at that beat.
REQ-015 o_rd_err SHALL clear only on reset or on an accepted frame_start.
REQ-016 Address arithmetic SHALL be 32-bit. Bursts are 128-byte aligned and SHALL never cross a 4 KB boundary.

Reset
REQ-017 While rst=1, SHALL force state=IDLE and ARVALID=RREADY=o_valid=frame_busy=frame_done=o_rd_err=0, ADDR_OFFSET=0, ARADDR=0, o_data=0.
REQ-018 Reset asserted mid-burst SHALL abandon the burst immediately; no recovery of the in-flight burst is required.

Structure
REQ-019 A shared package SHALL hold the FSM state encodings, the AXI constants (ARSIZE, ARBURST, ARCACHE, ARPROT, RRESP_OKAY), and BURST_BYTES=128.
REQ-020 One sub-module, axi_rd_beat_checker, SHALL own the beat counter and the RLAST/RRESP error detection. The FSM and datapath SHALL stay in the top module.

Verification
REQ-021 FRAME_BYTES=512, base 32'h1000_0000, ARREADY after 2 cycles, RVALID continuous -> ARADDR 0x10000000, 0x10000080, 0x10000100, 0x10000180; 64 o_valid words; one frame_done pulse.
REQ-022 i_prog_full=1 for 20 cycles after the first burst -> state stays CHECK and ARVALID=0 throughout; the second AR issues 1 cycle after i_prog_full falls.
REQ-023 RRESP=2'b10 on beat 5 -> o_rd_err=1 stays set through frame_done; all 16 words still appear on o_data.
REQ-024 RLAST on beat 12 -> o_rd_err=1; the FSM advances to CHECK; ADDR_OFFSET increments by 128.
REQ-025 frame_start re-pulsed mid-frame, then rst asserted during DATA -> the second start is ignored; after rst all outputs are 0 and state=0 within the same cycle.
REQ-026 base 32'h1000_0047 -> first ARADDR=32'h1000_0000.
